fib_stream_gen: RTL and testbench
=================================

# fib_stream_gen

Parametrised Fibonacci-style sequence generator with a valid/ready output stream. It is the successor to the free-running fixed-width Fibonacci counter. New in this generation: configurable width, programmable seeds and term count, start/done handshake, back-pressure, one-shot or continuous mode, abort, and overflow reporting. It sits as a stream source in front of downstream datapath/test blocks.

## Interface
- WIDTH, 32, term width in bits (≥2)
- CNT_W, 16, width of term-count input and internal index
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a new sequence; sampled only in IDLE
- abort  in  1  terminate the running sequence; sampled only in RUN
- n  in  CNT_W  number of terms per pass; captured at start
- seed0  in  WIDTH  term 0; captured at start
- seed1  in  WIDTH  term 1; captured at start
- mode  in  1  0 = one-shot, 1 = continuous (restart from seeds after each pass); captured at start
- out_ready  in  1  downstream accepts out_data
- out_data  out  WIDTH  current term
- out_valid  out  1  out_data is valid
- out_last  out  1  out_data is the final term (index n-1) of the current pass
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on one-shot completion, or on n==0
- overflow  out  1  sticky; a presented term's true value exceeded 2^WIDTH-1

## Operation
- Sequence: t0=seed0, t1=seed1, tk=(tk-1 + tk-2) mod 2^WIDTH. Addition is WIDTH+1 bits; the carry marks overflow.
- States: IDLE, RUN.
- IDLE + start, n≥1: capture n, seeds, mode. Load term 0 into out_data, set out_valid, clear overflow, go to RUN.
- IDLE + start, n==0: no output, done pulses for one cycle, stay IDLE. overflow is cleared.
- RUN: a term is accepted when out_valid & out_ready. On accept of index k<n-1, present index k+1 on the next cycle.
- Accept of index n-1 (out_last high):
  - mode 0: out_valid drops, done pulses, go to IDLE.
  - mode 1: present seed0 (index 0) on the next cycle, stay in RUN, no done. overflow is not cleared between passes.
- n==1: seed0 is presented with out_last high. n==2: seed0, then seed1 with out_last high.
- Back-pressure: while out_valid & !out_ready, out_data, out_last and out_valid hold stable.
- abort in RUN wins over a simultaneous accept. On the next cycle out_valid drops and the state is IDLE. No done pulse; overflow holds.
- start while in RUN, and abort while in IDLE, are ignored.
- overflow rises in the same cycle the wrapped term first appears on out_data. Precomputation of terms with index ≥n must never set it. overflow holds until the next accepted start or reset.
- Changes to n, seeds or mode during RUN have no effect.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces all outputs to 0 and the state to IDLE. Asserting reset mid-sequence discards the sequence immediately; no done pulse.
- start sampled at edge t: out_valid and term 0 are visible after edge t, so the first beat can be accepted at edge t+1.
- Throughput is one term per cycle with out_ready held high. n terms are accepted at edges t+1 … t+n.
- done is high for exactly the cycle after the final accept, aligned with out_valid falling. For n==0, done is high for the cycle after the start edge.
- busy equals (state==RUN). It falls in the same cycle that done rises.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- WIDTH=32, seeds 0/1, n=8, mode 0, out_ready=1 -> out_data 0,1,1,2,3,5,8,13 on consecutive cycles, out_last on 13. done pulses once; overflow=0.
- Same run with out_ready toggled 1,0,0,1,… -> identical term order, data stable during stalls. done comes only after 13 is accepted.
- WIDTH=8, seeds 0/1, n=15 -> term 13 = 233 with overflow=0. Term 14 = 121 (377 mod 256) with overflow rising in the same cycle, held after done. The next start clears it.
- Seeds 2/1, n=3, mode 1 -> 2,1,3(last),2,1,3(last),… with no done. abort asserted with a pending accept -> out_valid=0 on the next cycle, IDLE, done stays 0.
- n=0 start -> no out_valid, done for one cycle. n=1, seed0=7 -> single beat 7 with out_last, then done.
- reset_n pulsed low mid-sequence (after 3 beats) -> all outputs 0 immediately. start after release restarts from seed0.

Source files
------------

// File: rtl/fib_stream_gen.sv
// Fibonacci-style term generator with valid/ready output, programmable seeds/count/mode.
// Latency: term 0 visible the cycle after start; one term per cycle while out_ready is high.
// Backpressure: out_valid/out_data/out_last hold while out_ready is low; abort wins over accept.
module fib_stream_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic             mode,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state, state_nxt;

  // Captured configuration for the running sequence
  logic [CNT_W-1:0] n_r, n_r_nxt;
  logic [WIDTH-1:0] seed0_r, seed0_r_nxt;
  logic [WIDTH-1:0] seed1_r, seed1_r_nxt;
  logic             mode_r, mode_r_nxt;

  // idx is the index of the term currently on out_data; prev holds term idx-1
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt, last_nxt, done_nxt, ovf_nxt;

  logic             accept;
  logic [WIDTH:0]   sum;

  assign accept = out_valid & out_ready;
  // One extra bit so the carry shows a wrapped term
  assign sum    = {1'b0, prev} + {1'b0, out_data};
  assign busy   = (state == RUN);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: abort beats a simultaneous final accept
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (start && (n != '0)) state_nxt = RUN;
    end else begin
      if (abort)                                state_nxt = IDLE;
      else if (accept && out_last && !mode_r)   state_nxt = IDLE;
    end
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    n_r_nxt     = n_r;
    seed0_r_nxt = seed0_r;
    seed1_r_nxt = seed1_r;
    mode_r_nxt  = mode_r;
    idx_nxt     = idx;
    prev_nxt    = prev;
    data_nxt    = out_data;
    valid_nxt   = out_valid;
    last_nxt    = out_last;
    done_nxt    = 1'b0;
    ovf_nxt     = overflow;
    if (state == IDLE) begin
      if (start) begin
        ovf_nxt = 1'b0;
        if (n == '0) begin
          done_nxt = 1'b1;
        end else begin
          n_r_nxt     = n;
          seed0_r_nxt = seed0;
          seed1_r_nxt = seed1;
          mode_r_nxt  = mode;
          idx_nxt     = '0;
          prev_nxt    = '0;
          data_nxt    = seed0;
          valid_nxt   = 1'b1;
          last_nxt    = (n == ONE);
        end
      end
    end else begin
      if (abort) begin
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
      end else if (accept) begin
        if (out_last) begin
          if (mode_r) begin
            // Continuous: restart the pass from the captured seeds
            idx_nxt  = '0;
            prev_nxt = '0;
            data_nxt = seed0_r;
            last_nxt = (n_r == ONE);
          end else begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end else begin
          // Only terms with index < n are ever computed, so overflow is never premature
          idx_nxt  = idx + ONE;
          prev_nxt = out_data;
          last_nxt = ((idx + ONE) == (n_r - ONE));
          if (idx == '0) begin
            data_nxt = seed1_r;
          end else begin
            data_nxt = sum[WIDTH-1:0];
            if (sum[WIDTH]) ovf_nxt = 1'b1;
          end
        end
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_r       <= '0;
      seed0_r   <= '0;
      seed1_r   <= '0;
      mode_r    <= 1'b0;
      idx       <= '0;
      prev      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      n_r       <= n_r_nxt;
      seed0_r   <= seed0_r_nxt;
      seed1_r   <= seed1_r_nxt;
      mode_r    <= mode_r_nxt;
      idx       <= idx_nxt;
      prev      <= prev_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
      done      <= done_nxt;
      overflow  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_fib_stream_gen.sv
// Scoreboard bench for fib_stream_gen (WIDTH=8 so wrap-around is reachable).
// Expected beats are queued at stimulus time; a negedge monitor pops on each accept.
// Stall stability and done/queue alignment are checked by the monitor as well.
module tb_fib_stream_gen;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [7:0] n;
  logic [7:0] seed0;
  logic [7:0] seed1;
  logic       mode;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       overflow;

  fib_stream_gen #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .n(n),
    .seed0(seed0), .seed1(seed1), .mode(mode), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       o;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  // Hand-computed seeds 0/1 sequence in 8 bits; index 14 is 377 mod 256
  logic [7:0] fibtab [0:14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                                8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
  logic pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic o);
    exp_t x;
    x.d = d; x.l = l; x.o = o;
    q.push_back(x);
  endtask

  task automatic push_fib(input int cnt, input int total);
    for (int k = 0; k < cnt; k++)
      push(fibtab[k], (k == total - 1), (k == 14));
  endtask

  task automatic do_start(input logic [7:0] nn, input logic [7:0] s0,
                          input logic [7:0] s1, input logic m);
    @(posedge clk); #1;
    n = nn; seed0 = s0; seed1 = s1; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string nm);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({nm, "_done_seen"}, done_cnt, d0 + 1);
    chk({nm, "_valid_low"}, out_valid, 0);
    chk({nm, "_busy_low"}, busy, 0);
  endtask

  // Monitor: stall stability, done/queue alignment, scoreboard compare on accept
  logic       stall = 1'b0;
  logic [7:0] st_data;
  logic       st_last;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("done_after_last_beat", q.size(), 0);
      end
      if (stall && out_valid) begin
        chk("stall_data", out_data, st_data);
        chk("stall_last", out_last, st_last);
      end
      stall   = out_valid && !out_ready;
      st_data = out_data;
      st_last = out_last;
      if (out_valid && out_ready && !(abort && busy)) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_last", out_last, e.l);
          chk("beat_overflow", overflow, e.o);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; n = '0;
    seed0 = '0; seed1 = '0; mode = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk); reset_n = 1'b1;

    // Basic one-shot run, n=8
    push_fib(8, 8);
    d0 = done_cnt;
    do_start(8'd8, 8'd0, 8'd1, 1'b0);
    chk("run_busy", busy, 1);
    wait_done(d0, 40, "basic");
    chk("basic_ovf", overflow, 0);

    // Same run with out_ready toggling 1,0,0,1
    push_fib(8, 8);
    d0 = done_cnt;
    do_start(8'd8, 8'd0, 8'd1, 1'b0);
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      out_ready = pat[i % 4];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("stall_done_count", done_cnt, d0 + 1);

    // 15 terms: the last one wraps and raises overflow
    push_fib(15, 15);
    d0 = done_cnt;
    do_start(8'd15, 8'd0, 8'd1, 1'b0);
    wait_done(d0, 60, "ovf");
    chk("ovf_held_after_done", overflow, 1);

    // n=0: no beat, single done, overflow cleared
    d0 = done_cnt;
    do_start(8'd0, 8'd0, 8'd1, 1'b0);
    @(negedge clk); #1;
    chk("n0_done", done, 1);
    chk("n0_valid", out_valid, 0);
    chk("n0_busy", busy, 0);
    chk("n0_ovf_cleared", overflow, 0);
    @(negedge clk); #1;
    chk("n0_done_one_cycle", done, 0);
    chk("n0_done_count", done_cnt, d0 + 1);

    // n=1 single beat
    push(8'd7, 1'b1, 1'b0);
    d0 = done_cnt;
    do_start(8'd1, 8'd7, 8'd3, 1'b0);
    wait_done(d0, 20, "n1");

    // Continuous mode with an ignored start mid-run, then abort against a pending accept
    push(8'd2, 1'b0, 1'b0); push(8'd1, 1'b0, 1'b0); push(8'd3, 1'b1, 1'b0);
    push(8'd2, 1'b0, 1'b0); push(8'd1, 1'b0, 1'b0); push(8'd3, 1'b1, 1'b0);
    d0 = done_cnt;
    do_start(8'd3, 8'd2, 8'd1, 1'b1);
    repeat (2) @(posedge clk);
    #1; start = 1'b1; n = 8'd5; seed0 = 8'd9; mode = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; abort = 1'b1;
    @(negedge clk);
    chk("cont_queue_drained", q.size(), 0);
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk); #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done_cnt, d0);

    // Reset mid-sequence after 3 beats
    push_fib(3, 8);
    do_start(8'd8, 8'd0, 8'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_queue", q.size(), 0);
    @(negedge clk); reset_n = 1'b1;

    // Restart after reset begins at seed0
    push_fib(8, 8);
    d0 = done_cnt;
    do_start(8'd8, 8'd0, 8'd1, 1'b0);
    wait_done(d0, 40, "restart");

    chk("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
